vip_pattern_frame_gen: RTL and testbench

Synthetic pixel-stream source for the VIP chain. It generates `per_frame_vsync` / `per_frame_href` / `per_frame_clken` / `per_img_Y` timing and 8-bit luma test patterns. The stream has the same framing that the matrix generator and the Sobel edge detector consume. It replaces the CMOS front end for bring-up, threshold tuning and regression, so the edge pipeline can run against known images without a sensor.

---
 rtl/vip_pattern_frame_gen.sv | 219 +++++++++++++++++++++
 tb/tb_vip_pattern_frame_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_pattern_frame_gen.sv
// vip_pattern_frame_gen: synthetic VIP pixel-stream source producing
// vsync/href/clken framing and 8-bit luma test patterns.
// Optional feature macro: VIP_PATTERN_MOVING_EN (scrolls the box pattern
// one pixel per frame with horizontal wrap; static box when undefined).
module vip_pattern_frame_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 2,
  parameter int V_BACK      = 8,
  parameter int V_FRONT     = 2,
  parameter int CLKEN_DIV   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       per_frame_vsync,
  output logic       per_frame_href,
  output logic       per_frame_clken,
  output logic [7:0] per_img_Y,
  output logic       frame_done,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int XPW      = HW + 1;
  localparam int LMAX_A   = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int LMAX_B   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int LINE_MAX = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
  localparam int LW       = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int DW       = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT_W  = HW'(H_ACTIVE);
  localparam logic [XPW-1:0] BOX_X_LO = XPW'(H_ACTIVE / 4);
  localparam logic [XPW-1:0] BOX_X_HI = XPW'((3 * H_ACTIVE) / 4);
  localparam logic [LW-1:0]  BOX_Y_LO = LW'(V_ACTIVE / 4);
  localparam logic [LW-1:0]  BOX_Y_HI = LW'((3 * V_ACTIVE) / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [HW-1:0]   h_cnt, h_nxt;
  logic [LW-1:0]   line_cnt, line_nxt;
  logic [LW-1:0]   cur_last;
  logic            line_end;
  logic            last_line;
  logic            frame_start;
  logic            frame_end;
  logic [1:0]      pat_q;
  logic            href_c;
  logic [7:0]      x8;
  logic            y_b4;
  logic [XPW-1:0]  xp;
  logic            in_box;
  logic [7:0]      pix_c;

  assign tick = (div_cnt == DW'(CLKEN_DIV - 1));

  // Free-running pixel-slot divider; stays at 0 when CLKEN_DIV is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Last line index of the current vertical region.
  always_comb begin
    cur_last = '0;
    case (state)
      S_VSYNC:  cur_last = LW'(VSYNC_LINES - 1);
      S_VBACK:  cur_last = LW'(V_BACK - 1);
      S_ACTIVE: cur_last = LW'(V_ACTIVE - 1);
      S_VFRONT: cur_last = LW'(V_FRONT - 1);
      default:  cur_last = '0;
    endcase
  end

  // Next-state and counter advance; everything moves only on a tick.
  always_comb begin
    state_nxt   = state;
    h_nxt       = h_cnt;
    line_nxt    = line_cnt;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    line_end    = (h_cnt == H_LAST);
    last_line   = (line_cnt == cur_last);
    if (tick) begin
      if (state == S_IDLE) begin
        if (enable) begin
          state_nxt   = S_VSYNC;
          h_nxt       = '0;
          line_nxt    = '0;
          frame_start = 1'b1;
        end
      end else begin
        h_nxt = line_end ? '0 : h_cnt + HW'(1);
        if (line_end) begin
          if (last_line) begin
            line_nxt = '0;
            case (state)
              S_VSYNC:  state_nxt = (V_BACK == 0) ? S_ACTIVE : S_VBACK;
              S_VBACK:  state_nxt = S_ACTIVE;
              S_ACTIVE: state_nxt = S_VFRONT;
              S_VFRONT: begin
                frame_end = 1'b1;
                if (enable) begin
                  state_nxt   = S_VSYNC;
                  frame_start = 1'b1;
                end else begin
                  state_nxt = S_IDLE;
                end
              end
              default:  state_nxt = S_IDLE;
            endcase
          end else begin
            line_nxt = line_cnt + LW'(1);
          end
        end
      end
    end
  end

  // Timing state registers and frame-start pattern latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      h_cnt    <= '0;
      line_cnt <= '0;
      pat_q    <= '0;
    end else begin
      state    <= state_nxt;
      h_cnt    <= h_nxt;
      line_cnt <= line_nxt;
      if (frame_start) begin
        pat_q <= pattern_sel;
      end
    end
  end

`ifdef VIP_PATTERN_MOVING_EN
  logic [HW-1:0] off;

  // Box offset advances once per frame start, wrapping at H_ACTIVE-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off <= '0;
    end else if (frame_start) begin
      off <= (off == HW'(H_ACTIVE - 1)) ? '0 : off + HW'(1);
    end
  end

  // Horizontal position relative to the scrolling origin, wrapped into 0..H_ACTIVE-1.
  always_comb begin
    if (h_cnt >= off) begin
      xp = {1'b0, h_cnt} - {1'b0, off};
    end else begin
      xp = {1'b0, h_cnt} + XPW'(H_ACTIVE) - {1'b0, off};
    end
  end
`else
  // Static box: position is the raw horizontal count.
  always_comb begin
    xp = {1'b0, h_cnt};
  end
`endif

  // Pixel decode from current counters; registered below.
  always_comb begin
    href_c = (state == S_ACTIVE) && (h_cnt < H_ACT_W);
    x8     = 8'(h_cnt);
    y_b4   = |(line_cnt & LW'(16));
    in_box = (xp >= BOX_X_LO) && (xp < BOX_X_HI) &&
             (line_cnt >= BOX_Y_LO) && (line_cnt < BOX_Y_HI);
    pix_c  = '0;
    case (pat_q)
      2'd0:    pix_c = x8;
      2'd1:    pix_c = x8[5] ? '1 : '0;
      2'd2:    pix_c = (x8[4] ^ y_b4) ? '1 : '0;
      default: pix_c = in_box ? '1 : '0;
    endcase
  end

  // Registered outputs, one cycle behind the counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_frame_vsync <= 1'b0;
      per_frame_href  <= 1'b0;
      per_frame_clken <= 1'b0;
      per_img_Y       <= '0;
      frame_done      <= 1'b0;
      frame_cnt       <= '0;
    end else begin
      per_frame_vsync <= (state == S_VSYNC);
      per_frame_href  <= href_c;
      per_frame_clken <= tick & href_c;
      per_img_Y       <= href_c ? pix_c : '0;
      frame_done      <= frame_end;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vip_pattern_frame_gen.sv
// Directed testbench for vip_pattern_frame_gen: small 8x4 frames, one
// instance with CLKEN_DIV=1 and one with CLKEN_DIV=3.
module tb_vip_pattern_frame_gen;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [1:0]  pattern_sel;
  logic        vsync, href, clken, fdone;
  logic [7:0]  y;
  logic [15:0] fcnt;

  logic        rst3, enable3;
  logic [1:0]  pattern_sel3;
  logic        vsync3, href3, clken3, fdone3;
  logic [7:0]  y3;
  logic [15:0] fcnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vip_pattern_frame_gen #(
    .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LINES(1),
    .V_BACK(1), .V_FRONT(1), .CLKEN_DIV(1)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_Y(y), .frame_done(fdone), .frame_cnt(fcnt)
  );

  vip_pattern_frame_gen #(
    .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LINES(1),
    .V_BACK(1), .V_FRONT(1), .CLKEN_DIV(3)
  ) u_div (
    .clk(clk), .rst(rst3), .enable(enable3), .pattern_sel(pattern_sel3),
    .per_frame_vsync(vsync3), .per_frame_href(href3), .per_frame_clken(clken3),
    .per_img_Y(y3), .frame_done(fdone3), .frame_cnt(fcnt3)
  );

  // Box offset seen by the n-th frame after reset.
  function automatic int frame_off(input int n);
`ifdef VIP_PATTERN_MOVING_EN
    return n % 8;
`else
    return 0 * n;
`endif
  endfunction

  // Expected luma for an 8x4 active window.
  function automatic logic [7:0] exp_y(input int pat, input int x, input int yy, input int off);
    int xp;
    case (pat)
      0: return 8'(x);
      1: return x[5] ? 8'hFF : 8'h00;
      2: return (x[4] ^ yy[4]) ? 8'hFF : 8'h00;
      default: begin
        xp = (x >= off) ? x - off : x + 8 - off;
        return (xp >= 2 && xp < 6 && yy >= 1 && yy < 3) ? 8'hFF : 8'h00;
      end
    endcase
  endfunction

  // Raise enable from idle; vsync must be low one sample later and high the next.
  task automatic start_frame(input string tag);
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (vsync !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early_vsync got=%b exp=0", tag, vsync);
    end
    @(negedge clk);
    n_checks++;
    if (vsync !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_vsync_start got=%b exp=1", tag, vsync);
    end
  endtask

  // Check one full 84-cycle frame starting at the sample where vsync is first high.
  task automatic run_frame(input int pat, input int off, input int exp_cnt,
                           input int chg_k, input logic [1:0] chg_pat, input int drop_k);
    int line, h;
    logic hr;
    logic [11:0] exp_v, got_v;
    for (int k = 0; k < 84; k++) begin
      line  = k / 12;
      h     = k % 12;
      hr    = (line >= 2 && line <= 5 && h < 8);
      exp_v = {(line == 0), hr, hr, (hr ? exp_y(pat, h, line - 2, off) : 8'h00), (k == 83)};
      got_v = {vsync, href, clken, y, fdone};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL frame%0d_k%0d {vs,hr,ce,Y,fd} got=%h exp=%h", exp_cnt, k, got_v, exp_v);
      end
      if (k == 83) begin
        n_checks++;
        if (fcnt !== 16'(exp_cnt)) begin
          n_fail++;
          $display("FAIL frame_cnt got=%0d exp=%0d", fcnt, exp_cnt);
        end
      end
      if (k == chg_k) pattern_sel = chg_pat;
      if (k == drop_k) enable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({vsync, href, clken, y, fdone} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=000", {vsync, href, clken, y, fdone});
    end
    n_checks++;
    if (fcnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_frame_cnt got=%0d exp=0", fcnt);
    end
    n_checks++;
    if ({vsync3, href3, clken3, y3, fdone3, fcnt3} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_div_outputs got=%h exp=0", {vsync3, href3, clken3, y3, fdone3, fcnt3});
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({vsync, href, fdone} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_no_enable cyc%0d got=%b exp=000", i, {vsync, href, fdone});
      end
    end
  endtask

  task automatic test_ramp;
    pattern_sel = 2'd0;
    start_frame("ramp");
    run_frame(0, frame_off(1), 1, -1, 2'd0, -1);
  endtask

  task automatic test_pattern_change;
    run_frame(0, frame_off(2), 2, 40, 2'd2, -1);
    run_frame(2, frame_off(3), 3, 40, 2'd3, -1);
    run_frame(3, frame_off(4), 4, -1, 2'd3, -1);
  endtask

  task automatic test_enable_drop;
    run_frame(3, frame_off(5), 5, -1, 2'd3, 30);
    for (int i = 0; i < 30; i++) begin
      n_checks++;
      if ({vsync, href, clken, fdone} !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_after_drop cyc%0d got=%b exp=0000", i, {vsync, href, clken, fdone});
      end
      @(negedge clk);
    end
    n_checks++;
    if (fcnt !== 16'd5) begin
      n_fail++;
      $display("FAIL frame_cnt_idle got=%0d exp=5", fcnt);
    end
  endtask

  task automatic test_reenable;
    start_frame("reenable");
    run_frame(3, frame_off(6), 6, -1, 2'd3, -1);
  endtask

  task automatic test_reset_midline;
    repeat (30) @(negedge clk);
    n_checks++;
    if (href !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_href got=%b exp=1", href);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({vsync, href, clken, y, fdone, fcnt} !== 28'h0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=0", {vsync, href, clken, y, fdone, fcnt});
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({vsync, href, clken, y, fdone, fcnt} !== 28'h0) begin
        n_fail++;
        $display("FAIL post_reset_quiet cyc%0d got=%h exp=0", i, {vsync, href, clken, y, fdone, fcnt});
      end
    end
    start_frame("after_reset");
    run_frame(3, frame_off(1), 1, -1, 2'd3, -1);
    enable = 1'b0;
  endtask

  task automatic test_clken_div;
    int s, ph, line, h, wait_n;
    logic hr;
    logic [11:0] exp_v, got_v;
    pattern_sel3 = 2'd0;
    @(negedge clk);
    rst3    = 1'b0;
    enable3 = 1'b1;
    wait_n  = 0;
    while (vsync3 !== 1'b1 && wait_n < 12) begin
      @(negedge clk);
      wait_n++;
    end
    n_checks++;
    if (vsync3 !== 1'b1) begin
      n_fail++;
      $display("FAIL div_vsync_timeout got=%b exp=1", vsync3);
    end
    for (int k = 0; k < 252; k++) begin
      s     = k / 3;
      ph    = k % 3;
      line  = s / 12;
      h     = s % 12;
      hr    = (line >= 2 && line <= 5 && h < 8);
      exp_v = {(line == 0), hr, (hr && ph == 2), (hr ? 8'(h) : 8'h00), (k == 251)};
      got_v = {vsync3, href3, clken3, y3, fdone3};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL div_k%0d {vs,hr,ce,Y,fd} got=%h exp=%h", k, got_v, exp_v);
      end
      if (k == 251) begin
        n_checks++;
        if (fcnt3 !== 16'd1) begin
          n_fail++;
          $display("FAIL div_frame_cnt got=%0d exp=1", fcnt3);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (vsync3 !== 1'b1) begin
      n_fail++;
      $display("FAIL div_next_vsync got=%b exp=1", vsync3);
    end
    enable3 = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    pattern_sel  = 2'd0;
    rst3         = 1'b1;
    enable3      = 1'b0;
    pattern_sel3 = 2'd0;
    test_reset;
    test_ramp;
    test_pattern_change;
    test_enable_drop;
    test_reenable;
    test_reset_midline;
    test_clken_div;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
